// File: rtl/cic_decimator_prog.sv
// Multi-channel CIC decimator with a runtime-programmable ratio R in 2..2^STG_GSZ.
// Build macro CIC_ROUND_EN selects round-half-up output with positive saturation instead of truncation.
module cic_decimator_prog #(
  parameter int NUM_STAGES = 3,
  parameter int STG_GSZ    = 5,
  parameter int ISZ        = 16,
  parameter int OSZ        = 16,
  parameter int NUM_CH     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [STG_GSZ:0]        dec_ratio,
  input  logic                    in_valid,
  input  logic [NUM_CH*ISZ-1:0]   in,
  output logic                    out_valid,
  output logic [NUM_CH*OSZ-1:0]   out
);

  localparam int ASZ = ISZ + NUM_STAGES * STG_GSZ;
  localparam int RW  = STG_GSZ + 1;
  localparam int FW  = $clog2(NUM_STAGES + 2);
  localparam logic [RW-1:0] RMAX      = RW'(1) << STG_GSZ;
  localparam logic [FW-1:0] FLUSH_LEN = FW'(NUM_STAGES + 1);
`ifdef CIC_ROUND_EN
  localparam logic signed [ASZ:0] HALF = (ASZ+1)'(1) << (ASZ - OSZ - 1);
  localparam logic signed [ASZ:0] MAXP = ((ASZ+1)'(1) << (ASZ - 1)) - (ASZ+1)'(1);
`endif

  function automatic logic [RW-1:0] clamp_ratio(input logic [RW-1:0] r);
    logic [RW-1:0] c;
    if (r < RW'(2)) c = RW'(2);
    else if (r > RMAX) c = RMAX;
    else c = r;
    return c;
  endfunction

  function automatic logic [OSZ-1:0] scale_out(input logic signed [ASZ-1:0] v);
`ifdef CIC_ROUND_EN
    logic signed [ASZ:0] r;
    r = $signed({v[ASZ-1], v}) + HALF;
    if (r > MAXP) return {1'b0, {(OSZ-1){1'b1}}};
    else return OSZ'(r >>> (ASZ - OSZ));
`else
    return OSZ'(v >>> (ASZ - OSZ));
`endif
  endfunction

  logic [RW-1:0]           ract_q, ract_d, cnt_q, cnt_d;
  logic [RW-1:0]           new_ratio_s, ract_eff_s;
  logic                    load_q, load_d;
  logic [FW-1:0]           flush_q, flush_d;
  logic                    dec_stb_s, strobe_ok_s;
  logic [NUM_STAGES-1:0]   stb_q, stb_d;
  logic [NUM_STAGES:0]     vld_q, vld_d;
  logic signed [ASZ-1:0]   integ_q [NUM_CH][NUM_STAGES];
  logic signed [ASZ-1:0]   integ_d [NUM_CH][NUM_STAGES];
  logic signed [ASZ-1:0]   comb_q  [NUM_CH][NUM_STAGES];
  logic signed [ASZ-1:0]   comb_d  [NUM_CH][NUM_STAGES];
  logic signed [ASZ-1:0]   dly_q   [NUM_CH][NUM_STAGES];
  logic signed [ASZ-1:0]   dly_d   [NUM_CH][NUM_STAGES];
  logic signed [ASZ-1:0]   src_s   [NUM_CH][NUM_STAGES];
  logic [NUM_CH*OSZ-1:0]   out_q, out_d;
  logic                    out_valid_q, out_valid_d;

  // Phase counter, ratio latch and flush bookkeeping; a ratio change restarts the flush window.
  always_comb begin
    new_ratio_s = clamp_ratio(dec_ratio);
    ract_eff_s  = load_q ? new_ratio_s : ract_q;
    dec_stb_s   = in_valid && (cnt_q == (ract_eff_s - RW'(1)));
    strobe_ok_s = (flush_q == FW'(0));
    load_d      = 1'b0;
    ract_d      = ract_eff_s;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    if (dec_stb_s) begin
      cnt_d  = RW'(0);
      ract_d = new_ratio_s;
      if (new_ratio_s != ract_eff_s) flush_d = FLUSH_LEN;
      else if (!strobe_ok_s) flush_d = flush_q - FW'(1);
      else flush_d = flush_q;
    end else if (in_valid) begin
      cnt_d = cnt_q + RW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    stb_d = (stb_q << 1) | NUM_STAGES'(dec_stb_s);
    vld_d = (vld_q << 1) | (NUM_STAGES+1)'(dec_stb_s && strobe_ok_s);
  end

  // Integrators run on accepted samples; comb stage j fires on the strobe delayed j+1 cycles.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      src_s[c][0] = integ_q[c][NUM_STAGES-1];
      for (int s = 1; s < NUM_STAGES; s++) src_s[c][s] = comb_q[c][s-1];
      for (int s = 0; s < NUM_STAGES; s++) begin
        integ_d[c][s] = integ_q[c][s];
        if (stb_q[s]) begin
          comb_d[c][s] = src_s[c][s] - dly_q[c][s];
          dly_d[c][s]  = src_s[c][s];
        end else begin
          comb_d[c][s] = comb_q[c][s];
          dly_d[c][s]  = dly_q[c][s];
        end
      end
      if (in_valid) begin
        integ_d[c][0] = integ_q[c][0] + ASZ'($signed(in[c*ISZ +: ISZ]));
        for (int s = 1; s < NUM_STAGES; s++) integ_d[c][s] = integ_q[c][s] + integ_q[c][s-1];
      end else begin
        integ_d[c][0] = integ_q[c][0];
      end
    end
    if (vld_q[NUM_STAGES]) begin
      out_valid_d = 1'b1;
      for (int c = 0; c < NUM_CH; c++) out_d[c*OSZ +: OSZ] = scale_out(comb_q[c][NUM_STAGES-1]);
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight decimation result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ract_q      <= RMAX;
      cnt_q       <= RW'(0);
      load_q      <= 1'b1;
      flush_q     <= FLUSH_LEN;
      stb_q       <= '0;
      vld_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          integ_q[c][s] <= '0;
          comb_q[c][s]  <= '0;
          dly_q[c][s]   <= '0;
        end
      end
    end else begin
      ract_q      <= ract_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      flush_q     <= flush_d;
      stb_q       <= stb_d;
      vld_q       <= vld_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          integ_q[c][s] <= integ_d[c][s];
          comb_q[c][s]  <= comb_d[c][s];
          dly_q[c][s]   <= dly_d[c][s];
        end
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_decimator_prog.sv
// Self-checking bench for cic_decimator_prog: steady-state CIC gain model plus directed literal checks.
`timescale 1ns/1ps
module tb_cic_decimator_prog;
  localparam int N = 3, SG = 5, ISZ = 16, OSZ = 16, NCH = 2;
`ifdef CIC_ROUND_EN
  localparam longint EXP4 = 64'sd1;
`else
  localparam longint EXP4 = 64'sd0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [SG:0]          dec_ratio;
  logic                 in_valid;
  logic [NCH*ISZ-1:0]   in_bus;
  logic                 out_valid;
  logic [NCH*OSZ-1:0]   out_bus;

  cic_decimator_prog #(.NUM_STAGES(N), .STG_GSZ(SG), .ISZ(ISZ), .OSZ(OSZ), .NUM_CH(NCH)) dut (
    .clk(clk), .reset_n(reset_n), .dec_ratio(dec_ratio), .in_valid(in_valid),
    .in(in_bus), .out_valid(out_valid), .out(out_bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int r);
    if (r < 2) return 2;
    else if (r > 32) return 32;
    else return r;
  endfunction

  function automatic logic signed [15:0] scale(input longint y);
    longint s;
`ifdef CIC_ROUND_EN
    s = (y + 64'sd16384) >>> 15;
    if (s > 64'sd32767) s = 64'sd32767;
`else
    s = y >>> 15;
`endif
    return s[15:0];
  endfunction

  // Model: a settled N-stage CIC has DC gain R^N; outputs appear N+2 cycles after the strobe sample.
  typedef struct {
    int t;
    bit v;
    bit known;
    logic signed [15:0] o0;
    logic signed [15:0] o1;
  } item_t;
  item_t q[$];
  int t = 0, cnt, r_act, flush;
  bit ld;
  longint last_x[2];
  int run[2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      cnt = 0; ld = 1'b1; flush = N + 1; r_act = 32;
      run[0] = 0; run[1] = 0; last_x[0] = 0; last_x[1] = 0;
    end else begin
      int r_new, r_eff;
      longint x[2];
      longint r3;
      item_t it;
      t++;
      r_new = clamp(int'(dec_ratio));
      r_eff = ld ? r_new : r_act;
      ld = 1'b0;
      r_act = r_eff;
      if (in_valid) begin
        x[0] = longint'($signed(in_bus[15:0]));
        x[1] = longint'($signed(in_bus[31:16]));
        for (int k = 0; k < 2; k++) begin
          if (x[k] == last_x[k]) run[k]++;
          else begin run[k] = 1; last_x[k] = x[k]; end
        end
        if (cnt == r_eff - 1) begin
          r3 = longint'(r_eff) * r_eff * r_eff;
          it.t = t + N + 1;
          it.v = (flush == 0);
          it.known = (run[0] >= N * r_eff + N) && (run[1] >= N * r_eff + N);
          it.o0 = scale(x[0] * r3);
          it.o1 = scale(x[1] * r3);
          q.push_back(it);
          if (r_new != r_eff) flush = N + 1;
          else if (flush > 0) flush--;
          r_act = r_new;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  logic signed [15:0] e0 = 16'sd0, e1 = 16'sd0;
  bit ek = 1'b1;
  int vld_cnt = 0, last_vt = 0, prev_vt = 0;

  // Every-cycle comparison against the model; out holds between pulses.
  always @(negedge clk) begin
    bit ev;
    item_t it;
    ev = 1'b0;
    if (!reset_n) begin
      e0 = 16'sd0; e1 = 16'sd0; ek = 1'b1;
    end else if (q.size() > 0 && q[0].t == t) begin
      it = q.pop_front();
      if (it.v) begin
        ev = 1'b1; ek = it.known; e0 = it.o0; e1 = it.o1;
      end
    end
    check("out_valid", longint'(out_valid), longint'(ev));
    if (ek) begin
      check("out_ch0", longint'($signed(out_bus[15:0])), longint'(e0));
      check("out_ch1", longint'($signed(out_bus[31:16])), longint'(e1));
    end
    if (out_valid) begin
      vld_cnt++;
      prev_vt = last_vt;
      last_vt = t;
    end
  end

  task automatic set_in(input logic signed [15:0] c0, input logic signed [15:0] c1);
    in_bus = {c1, c0};
  endtask

  task automatic run_samples(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int base;

  initial begin
    reset_n = 1'b0; dec_ratio = 6'd32; in_valid = 1'b0; in_bus = '0;
    repeat (3) @(negedge clk);
    check("rst_out", longint'(out_bus), 64'sd0);
    check("rst_valid", longint'(out_valid), 64'sd0);
    reset_n = 1'b1;

    set_in(16'sd1000, -16'sd1000);
    run_samples(256);
    idle(6);
    check("r32_ch0", longint'($signed(out_bus[15:0])), 64'sd1000);
    check("r32_ch1", longint'($signed(out_bus[31:16])), -64'sd1000);
    check("r32_period", longint'(last_vt - prev_vt), 64'sd128);

    dec_ratio = 6'd16;
    run_samples(32 + 128);
    idle(6);
    check("r16_ch0", longint'($signed(out_bus[15:0])), 64'sd125);

    run_samples(8);
    dec_ratio = 6'd32;
    base = vld_cnt;
    run_samples(8 + 160);
    idle(6);
    check("chg_pulses", longint'(vld_cnt - base), 64'sd2);
    check("chg_ch0", longint'($signed(out_bus[15:0])), 64'sd1000);

    dec_ratio = 6'd16;
    set_in(16'sd4, -16'sd4);
    run_samples(32 + 128);
    idle(6);
    check("small_ch0", longint'($signed(out_bus[15:0])), EXP4);

    dec_ratio = 6'd32;
    set_in(-16'sd32768, -16'sd4);
    run_samples(16 + 192);
    idle(6);
    check("neg_full", longint'($signed(out_bus[15:0])), -64'sd32768);
    set_in(16'sd32767, -16'sd4);
    run_samples(128);
    idle(6);
    check("pos_full", longint'($signed(out_bus[15:0])), 64'sd32767);

    dec_ratio = 6'd0;
    run_samples(32 + 16);
    idle(6);
    check("clamp_lo_period", longint'(last_vt - prev_vt), 64'sd8);
    dec_ratio = 6'd40;
    run_samples(2 + 192);
    idle(6);
    check("clamp_hi_period", longint'(last_vt - prev_vt), 64'sd128);

    run_samples(10);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_out", longint'(out_bus), 64'sd0);
    check("async_rst_valid", longint'(out_valid), 64'sd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    base = vld_cnt;
    run_samples(128);
    idle(6);
    check("post_rst_flush", longint'(vld_cnt - base), 64'sd0);
    check("post_rst_hold", longint'(out_bus), 64'sd0);
    run_samples(32);
    idle(6);
    check("post_rst_first", longint'(vld_cnt - base), 64'sd1);
    check("post_rst_ch0", longint'($signed(out_bus[15:0])), 64'sd32767);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_decimator_prog.md
CIC_DECIMATOR_PROG -- requirements
Module: cic_decimator_prog

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, integrator/comb stage count.
REQ-002 SHALL have parameter STG_GSZ, default 5, log2 of maximum decimation ratio RMAX = 2^STG_GSZ.
REQ-003 SHALL have parameter ISZ, default 16, input sample width.
REQ-004 SHALL have parameter OSZ, default 16, output sample width.
REQ-005 SHALL have parameter NUM_CH, default 2, parallel channel count; local ASZ = ISZ + NUM_STAGES*STG_GSZ.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-008 dec_ratio  in  STG_GSZ+1  requested decimation ratio R.
REQ-009 in_valid  in  1  one-cycle strobe: in carries a sample for every channel.
REQ-010 in  in  NUM_CH*ISZ  signed samples; channel k at bits [k*ISZ +: ISZ].
REQ-011 out_valid  out  1  one-cycle strobe: out updated this cycle.
REQ-012 out  out  NUM_CH*OSZ  signed decimated samples; channel k at bits [k*OSZ +: OSZ].

Function
REQ-013 Per channel, NUM_STAGES cascaded ASZ-bit integrators SHALL update only on in_valid, stage 0 adding the sign-extended input; wrap-around is modulo 2^ASZ.
REQ-014 A phase counter SHALL count accepted in_valid samples 0..Ract-1; the sample accepted at count Ract-1 SHALL raise a decimation strobe and reset the count to 0.
REQ-015 Ract SHALL be dec_ratio clamped to 2..RMAX; it SHALL be sampled only at a decimation strobe (and at reset release) and take effect for the next period.
REQ-016 NUM_STAGES comb stages (differential delay 1) SHALL be pipelined at clock rate, stage j advancing one cycle after stage j-1, each acting only on its delayed strobe.
REQ-017 out_valid SHALL pulse exactly NUM_STAGES+2 clk cycles after the in_valid cycle that raised the decimation strobe, independent of in_valid spacing (back-to-back in_valid allowed).
REQ-018 Output SHALL be comb result bits [ASZ-1 : ASZ-OSZ] (full scale at R = RMAX; gain (R/RMAX)^NUM_STAGES at smaller R), post-processed per REQ-024.
REQ-019 When Ract changes, out_valid SHALL be suppressed for the next NUM_STAGES+1 decimation strobes (comb history flush); out holds its last value.
REQ-020 in_valid held low: no state SHALL change other than draining the comb pipeline; out holds.

Reset
REQ-021 reset_n low SHALL asynchronously clear all integrators, combs, delays, phase counter, strobe pipeline, out (all zeros) and out_valid (0).
REQ-022 After reset_n release, Ract SHALL load from dec_ratio on the first clk edge; the first NUM_STAGES+1 decimation strobes SHALL produce no out_valid.
REQ-023 Reset asserted mid-period or mid-pipeline SHALL discard in-flight results; no out_valid pulse after release from pre-reset data.

Configuration
REQ-024 Macro CIC_ROUND_EN defined: output SHALL be round-half-up (add 2^(ASZ-OSZ-1) before slicing) with saturation to +2^(OSZ-1)-1 on positive overflow; undefined: plain truncation per REQ-018, no rounding adder or saturation logic.

Verification (ISZ=16, OSZ=16, NUM_STAGES=3, STG_GSZ=5, NUM_CH=2, in_valid every 4th clk)
REQ-025 dec_ratio=32, ch0=+1000, ch1=-1000 constant -> after flush out ch0=1000, ch1=-1000; out_valid every 128 clk, NUM_STAGES+2=5 clk after completing in_valid.
REQ-026 dec_ratio=16, ch0=1000 -> settled ch0=125; then dec_ratio=32 mid-period -> change applies at next strobe, 4 strobes without out_valid, then 1000.
REQ-027 dec_ratio=16, ch0=+4 -> CIC_ROUND_EN: 1; without: 0; ch0=-32768 at R=32 -> -32768, ch0=+32767 -> 32767 both builds.
REQ-028 dec_ratio=0 and dec_ratio=40 -> behave as R=2 and R=32 (out_valid every 8 and 128 clk).
REQ-029 reset_n low 3 clk midway through a period -> out=0, out_valid=0 immediately (asynchronous); first valid output only after 4 further strobes.
